// File: rtl/memfu_pkg.sv
// Shared memfu types and constants for the load-to-dcache bank arbiter.
package memfu_pkg;

  localparam int LD_NBANK     = 4;
  localparam int LD_BANK_BITS = $clog2(LD_NBANK);
  localparam int LD_XLEN      = 64;
  localparam int LD_LQIDX_W   = 5;

  typedef logic [LD_BANK_BITS-1:0] ldBankIdx_t;

  typedef struct packed {
    logic [LD_XLEN-1:0]    vaddr;
    logic [LD_LQIDX_W-1:0] lqIdx;
    ldBankIdx_t            bank;
  } ld_bank_req_t;

  // Width of a pointer over n entries; a single entry still gets one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick_onehot.sv
// Cyclic priority picker: first requester at or after ptr wins, one-hot result.
module rr_pick_onehot
  import memfu_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/load_dcache_bank_arb.sv
// Arbitrates NLOAD load pipelines onto NBANK single-ported dcache data banks:
// s0 grant/conflict, s1 bank read issue, s2 data return to the owning channel.
module load_dcache_bank_arb
  import memfu_pkg::*;
#(
  parameter int NLOAD    = 2,
  parameter int NBANK    = LD_NBANK,
  parameter int BANK_LSB = 3,
  parameter int XLEN     = LD_XLEN,
  parameter int LQIDX_W  = LD_LQIDX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NLOAD-1:0]         ld_s0_req,
  input  logic [NLOAD*XLEN-1:0]    ld_s0_vaddr,
  input  logic [NLOAD*LQIDX_W-1:0] ld_s0_lqIdx,
  output logic [NLOAD-1:0]         ld_s0_gnt,
  output logic [NLOAD-1:0]         ld_s0_conflict,
  input  logic [NLOAD-1:0]         ld_s1_kill,
  output logic [NLOAD-1:0]         ld_s2_data_vld,
  output logic [NLOAD*LQIDX_W-1:0] ld_s2_lqIdx,
  output logic [NLOAD*XLEN-1:0]    ld_s2_data,
  input  logic [NBANK-1:0]         bk_busy,
  output logic [NBANK-1:0]         bk_req,
  output logic [NBANK*XLEN-1:0]    bk_addr,
  input  logic [NBANK*XLEN-1:0]    bk_rdata
);

  localparam int BB = ptr_width(NBANK);
  localparam int PW = ptr_width(NLOAD);

  typedef struct packed {
    logic [XLEN-1:0]    vaddr;
    logic [LQIDX_W-1:0] lqIdx;
    logic [BB-1:0]      bank;
  } ld_stage_t;

  logic [BB-1:0]      bank_s0     [NLOAD];
  logic [NLOAD-1:0]   bank_req    [NBANK];
  logic [NLOAD-1:0]   bank_win    [NBANK];
  logic [PW-1:0]      rr_ptr_reg;
  logic [NLOAD-1:0]   s1_vld_reg;
  logic [NLOAD-1:0]   s2_vld_reg;
  logic [NLOAD-1:0]   s1_fire;
  ld_stage_t          s1_reg      [NLOAD];
  logic [BB-1:0]      s2_bank_reg [NLOAD];
  logic [LQIDX_W-1:0] s2_lq_reg   [NLOAD];

  genvar gi, gj;

  // s0: per-bank round-robin among channels targeting that bank
  generate
    for (gi = 0; gi < NLOAD; gi++) begin : g_bank_s0
      assign bank_s0[gi] = ld_s0_vaddr[gi*XLEN+BANK_LSB +: BB];
    end
    for (gi = 0; gi < NBANK; gi++) begin : g_bank
      for (gj = 0; gj < NLOAD; gj++) begin : g_ch
        assign bank_req[gi][gj] = ld_s0_req[gj] && (bank_s0[gj] == BB'(gi));
      end
      rr_pick_onehot #(.N(NLOAD), .PW(PW)) u_pick (
        .req (bank_req[gi]),
        .ptr (rr_ptr_reg),
        .gnt (bank_win[gi])
      );
    end
    for (gi = 0; gi < NLOAD; gi++) begin : g_gnt
      assign ld_s0_gnt[gi] = ld_s0_req[gi] & bank_win[bank_s0[gi]][gi]
                           & ~bk_busy[bank_s0[gi]] & ~flush;
      assign ld_s0_conflict[gi] = ld_s0_req[gi] & ~ld_s0_gnt[gi] & ~flush;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= '0;
      s1_vld_reg <= '0;
      s2_vld_reg <= '0;
    end else begin
      if (|ld_s0_conflict)
        rr_ptr_reg <= (rr_ptr_reg == PW'(NLOAD-1)) ? '0 : rr_ptr_reg + 1'b1;
      s1_vld_reg <= ld_s0_gnt;
      s2_vld_reg <= s1_fire;
    end
  end

  // Payload registers need no reset: they are qualified by the valid flags.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NLOAD; i++) begin
      s1_reg[i].vaddr <= ld_s0_vaddr[i*XLEN +: XLEN];
      s1_reg[i].lqIdx <= ld_s0_lqIdx[i*LQIDX_W +: LQIDX_W];
      s1_reg[i].bank  <= bank_s0[i];
      s2_bank_reg[i]  <= s1_reg[i].bank;
      s2_lq_reg[i]    <= s1_reg[i].lqIdx;
    end
  end

  assign s1_fire = s1_vld_reg & ~ld_s1_kill & {NLOAD{~flush}};

  // s1: at most one firing channel per bank, so plain assignment suffices
  always_comb begin
    bk_req  = '0;
    bk_addr = '0;
    for (int b = 0; b < NBANK; b++) begin
      for (int i = 0; i < NLOAD; i++) begin
        if (s1_fire[i] && (s1_reg[i].bank == BB'(b))) begin
          bk_req[b]                 = 1'b1;
          bk_addr[b*XLEN +: XLEN]   = s1_reg[i].vaddr;
        end
      end
    end
  end

  generate
    for (gi = 0; gi < NLOAD; gi++) begin : g_s2
      assign ld_s2_data_vld[gi]                   = s2_vld_reg[gi] & ~flush;
      assign ld_s2_data[gi*XLEN +: XLEN]          = bk_rdata[s2_bank_reg[gi]*XLEN +: XLEN];
      assign ld_s2_lqIdx[gi*LQIDX_W +: LQIDX_W]   = s2_lq_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_load_dcache_bank_arb.sv
// Self-checking bench: directed vector table, randomized traffic against a
// cycle-level reference model, and a mid-operation reset sequence.
module tb_load_dcache_bank_arb;

  localparam int NL = 2;
  localparam int NB = 4;
  localparam int XL = 64;
  localparam int LW = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [NL-1:0]    ld_s0_req;
  logic [NL*XL-1:0] ld_s0_vaddr;
  logic [NL*LW-1:0] ld_s0_lqIdx;
  logic [NL-1:0]    ld_s0_gnt;
  logic [NL-1:0]    ld_s0_conflict;
  logic [NL-1:0]    ld_s1_kill;
  logic [NL-1:0]    ld_s2_data_vld;
  logic [NL*LW-1:0] ld_s2_lqIdx;
  logic [NL*XL-1:0] ld_s2_data;
  logic [NB-1:0]    bk_busy;
  logic [NB-1:0]    bk_req;
  logic [NB*XL-1:0] bk_addr;
  logic [NB*XL-1:0] bk_rdata;

  always #5 clk = ~clk;

  load_dcache_bank_arb #(
    .NLOAD(NL), .NBANK(NB), .BANK_LSB(3), .XLEN(XL), .LQIDX_W(LW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ld_s0_req(ld_s0_req), .ld_s0_vaddr(ld_s0_vaddr), .ld_s0_lqIdx(ld_s0_lqIdx),
    .ld_s0_gnt(ld_s0_gnt), .ld_s0_conflict(ld_s0_conflict), .ld_s1_kill(ld_s1_kill),
    .ld_s2_data_vld(ld_s2_data_vld), .ld_s2_lqIdx(ld_s2_lqIdx), .ld_s2_data(ld_s2_data),
    .bk_busy(bk_busy), .bk_req(bk_req), .bk_addr(bk_addr), .bk_rdata(bk_rdata)
  );

  typedef struct {
    logic [NL-1:0] req;
    logic [63:0]   va0;
    logic [63:0]   va1;
    logic [NL-1:0] kill;
    logic [NB-1:0] busy;
    logic          fl;
    logic [NL-1:0] gnt;
    logic [NL-1:0] conf;
    logic [NB-1:0] bkreq;
    logic [NL-1:0] dvld;
  } vec_t;

  vec_t tab[15];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: outstanding reads per channel in s1 and s2, plus the
  // round-robin start channel.
  bit          m_s1_vld [NL];
  int          m_s1_bank[NL];
  logic [63:0] m_s1_va  [NL];
  logic [4:0]  m_s1_lq  [NL];
  bit          m_s2_vld [NL];
  int          m_s2_bank[NL];
  logic [4:0]  m_s2_lq  [NL];
  int          m_rr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NL; i++) begin
      m_s1_vld[i] = 0;
      m_s2_vld[i] = 0;
    end
    m_rr = 0;
  endtask

  task automatic apply(input logic [NL-1:0] req, input logic [63:0] va0, input logic [63:0] va1,
                       input logic [NL-1:0] kill, input logic [NB-1:0] busy, input logic fl);
    ld_s0_req         = req;
    ld_s0_vaddr[63:0] = va0;
    ld_s0_vaddr[127:64] = va1;
    ld_s0_lqIdx       = 10'($urandom);
    ld_s1_kill        = kill;
    bk_busy           = busy;
    flush             = fl;
    for (int b = 0; b < NB; b++) bk_rdata[b*XL +: XL] = {$urandom, $urandom};
  endtask

  // Compare one cycle against the model (and optional hand-written
  // expectations), then advance the model across the clock edge.
  task automatic step(input bit use_tab, input vec_t t);
    int            bank[NL];
    logic [NL-1:0] e_gnt, e_conf, e_dvld;
    logic [NB-1:0] e_bkreq;
    logic [63:0]   e_addr[NB];
    int            w;
    #3;
    e_gnt = '0; e_conf = '0; e_dvld = '0; e_bkreq = '0;
    for (int b = 0; b < NB; b++) e_addr[b] = '0;
    for (int i = 0; i < NL; i++) bank[i] = int'((ld_s0_vaddr[i*XL +: XL] >> 3) % NB);
    for (int i = 0; i < NL; i++) begin
      if (ld_s0_req[i]) begin
        w = -1;
        for (int k = 0; k < NL; k++) begin
          int j;
          j = (m_rr + k) % NL;
          if (w < 0 && ld_s0_req[j] && bank[j] == bank[i]) w = j;
        end
        e_gnt[i]  = (w == i) && !bk_busy[bank[i]] && !flush;
        e_conf[i] = !e_gnt[i] && !flush;
      end
    end
    for (int i = 0; i < NL; i++) begin
      if (m_s1_vld[i] && !ld_s1_kill[i] && !flush) begin
        e_bkreq[m_s1_bank[i]] = 1'b1;
        e_addr[m_s1_bank[i]]  = m_s1_va[i];
      end
      e_dvld[i] = m_s2_vld[i] && !flush;
    end
    check("gnt", 64'(ld_s0_gnt), 64'(e_gnt));
    check("conflict", 64'(ld_s0_conflict), 64'(e_conf));
    check("bk_req", 64'(bk_req), 64'(e_bkreq));
    check("data_vld", 64'(ld_s2_data_vld), 64'(e_dvld));
    for (int b = 0; b < NB; b++)
      if (e_bkreq[b]) check("bk_addr", bk_addr[b*XL +: XL], e_addr[b]);
    for (int i = 0; i < NL; i++)
      if (e_dvld[i]) begin
        check("s2_data", ld_s2_data[i*XL +: XL], bk_rdata[m_s2_bank[i]*XL +: XL]);
        check("s2_lqIdx", 64'(ld_s2_lqIdx[i*LW +: LW]), 64'(m_s2_lq[i]));
      end
    if (use_tab) begin
      check("tab_gnt", 64'(ld_s0_gnt), 64'(t.gnt));
      check("tab_conflict", 64'(ld_s0_conflict), 64'(t.conf));
      check("tab_bk_req", 64'(bk_req), 64'(t.bkreq));
      check("tab_data_vld", 64'(ld_s2_data_vld), 64'(t.dvld));
    end
    $display("cyc=%0d rst=%b req=%b fl=%b kill=%b busy=%b gnt=%b conf=%b bk_req=%b dvld=%b",
             cyc, rst, ld_s0_req, flush, ld_s1_kill, bk_busy, ld_s0_gnt, ld_s0_conflict,
             bk_req, ld_s2_data_vld);
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (|e_conf) m_rr = (m_rr + 1) % NL;
      for (int i = 0; i < NL; i++) begin
        m_s2_vld[i]  = m_s1_vld[i] && !ld_s1_kill[i] && !flush;
        m_s2_bank[i] = m_s1_bank[i];
        m_s2_lq[i]   = m_s1_lq[i];
        m_s1_vld[i]  = e_gnt[i];
        m_s1_bank[i] = bank[i];
        m_s1_va[i]   = ld_s0_vaddr[i*XL +: XL];
        m_s1_lq[i]   = ld_s0_lqIdx[i*LW +: LW];
      end
    end
    cyc++;
    #1;
  endtask

  vec_t dummy;

  initial begin
    //               req    va0     va1     kill   busy     fl    gnt    conf   bkreq    dvld
    tab[0]  = '{2'b00, 64'h00, 64'h00, 2'b00, 4'b0000, 1'b0, 2'b00, 2'b00, 4'b0000, 2'b00};
    tab[1]  = '{2'b11, 64'h00, 64'h08, 2'b00, 4'b0000, 1'b0, 2'b11, 2'b00, 4'b0000, 2'b00};
    tab[2]  = '{2'b00, 64'h00, 64'h00, 2'b00, 4'b0000, 1'b0, 2'b00, 2'b00, 4'b0011, 2'b00};
    tab[3]  = '{2'b00, 64'h00, 64'h00, 2'b00, 4'b0000, 1'b0, 2'b00, 2'b00, 4'b0000, 2'b11};
    tab[4]  = '{2'b11, 64'h10, 64'h30, 2'b00, 4'b0000, 1'b0, 2'b01, 2'b10, 4'b0000, 2'b00};
    tab[5]  = '{2'b11, 64'h10, 64'h30, 2'b00, 4'b0000, 1'b0, 2'b10, 2'b01, 4'b0100, 2'b00};
    tab[6]  = '{2'b01, 64'h00, 64'h00, 2'b00, 4'b0001, 1'b0, 2'b00, 2'b01, 4'b0100, 2'b01};
    tab[7]  = '{2'b10, 64'h00, 64'h18, 2'b00, 4'b0000, 1'b0, 2'b10, 2'b00, 4'b0000, 2'b10};
    tab[8]  = '{2'b00, 64'h00, 64'h00, 2'b10, 4'b0000, 1'b0, 2'b00, 2'b00, 4'b0000, 2'b00};
    tab[9]  = '{2'b00, 64'h00, 64'h00, 2'b00, 4'b0000, 1'b0, 2'b00, 2'b00, 4'b0000, 2'b00};
    tab[10] = '{2'b01, 64'h20, 64'h00, 2'b00, 4'b0000, 1'b0, 2'b01, 2'b00, 4'b0000, 2'b00};
    tab[11] = '{2'b01, 64'h28, 64'h00, 2'b00, 4'b0000, 1'b0, 2'b01, 2'b00, 4'b0001, 2'b00};
    tab[12] = '{2'b01, 64'h30, 64'h00, 2'b00, 4'b0000, 1'b1, 2'b00, 2'b00, 4'b0000, 2'b00};
    tab[13] = '{2'b00, 64'h00, 64'h00, 2'b00, 4'b0000, 1'b0, 2'b00, 2'b00, 4'b0000, 2'b00};
    tab[14] = '{2'b00, 64'h00, 64'h00, 2'b00, 4'b0000, 1'b0, 2'b00, 2'b00, 4'b0000, 2'b00};
    dummy = tab[0];

    rst = 1'b1;
    apply(2'b00, 64'h0, 64'h0, 2'b00, 4'b0000, 1'b0);
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int r = 0; r < 15; r++) begin
      apply(tab[r].req, tab[r].va0, tab[r].va1, tab[r].kill, tab[r].busy, tab[r].fl);
      step(1'b1, tab[r]);
    end

    for (int n = 0; n < 400; n++) begin
      logic [NB-1:0] busy;
      logic [NL-1:0] kill;
      for (int b = 0; b < NB; b++) busy[b] = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NL; i++) kill[i] = ($urandom_range(0, 7) == 0);
      apply(2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, kill, busy,
            $urandom_range(0, 15) == 0);
      step(1'b0, dummy);
    end

    // Mid-operation reset: s1/s2 valid and a pending pointer advance are all discarded.
    if (m_rr != 0) begin
      apply(2'b11, 64'h10, 64'h30, 2'b00, 4'b0000, 1'b0);
      step(1'b0, dummy);
    end
    apply(2'b11, 64'h00, 64'h08, 2'b00, 4'b0000, 1'b0);
    step(1'b0, dummy);
    apply(2'b11, 64'h00, 64'h08, 2'b00, 4'b0000, 1'b0);
    step(1'b0, dummy);
    apply(2'b11, 64'h10, 64'h30, 2'b00, 4'b0000, 1'b0);
    rst = 1'b1;
    step(1'b0, dummy);
    rst = 1'b0;
    apply(2'b11, 64'h10, 64'h30, 2'b00, 4'b0000, 1'b0);
    step(1'b1, '{2'b11, 64'h10, 64'h30, 2'b00, 4'b0000, 1'b0, 2'b01, 2'b10, 4'b0000, 2'b00});
    apply(2'b00, 64'h0, 64'h0, 2'b00, 4'b0000, 1'b0);
    step(1'b1, '{2'b00, 64'h0, 64'h0, 2'b00, 4'b0000, 1'b0, 2'b00, 2'b00, 4'b0100, 2'b00});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
